// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the EX/MEM stage and a 32-bit
// request/acknowledge data-memory bus. It splits doubleword accesses into two
// beats, generates byte enables and replicated store data, and sign- or
// zero-extends load data. The pipeline is stalled while an access is in flight.
//
// Ports:
//   Clk, Rst_N          clock (rising edge), asynchronous active-low reset
//   in_addr             64-bit byte address from EX/MEM
//   in_wr_data          64-bit right-aligned store data
//   in_wr_en, in_rd_en  store / load request (store wins when both are high)
//   in_funct3           access size and signedness
//   out_rd_data         extended load result for MEM/WB (registered)
//   out_stall           pipeline freeze (combinational)
//   out_fault           misaligned or illegal request, valid in IDLE (combinational)
//   out_bus_*           registered bus request, write, address, data, byte enables
//   in_bus_ack          beat complete, in_bus_rdata valid this cycle
//   in_bus_rdata        32-bit read data
module mem_access_unit #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Rst_N,
   input  logic [63:0]           in_addr,
   input  logic [63:0]           in_wr_data,
   input  logic                  in_wr_en,
   input  logic                  in_rd_en,
   input  logic [2:0]            in_funct3,
   output logic [63:0]           out_rd_data,
   output logic                  out_stall,
   output logic                  out_fault,
   output logic                  out_bus_req,
   output logic                  out_bus_we,
   output logic [ADDR_WIDTH-1:0] out_bus_addr,
   output logic [31:0]           out_bus_wdata,
   output logic [3:0]            out_bus_be,
   input  logic                  in_bus_ack,
   input  logic [31:0]           in_bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e                state_q, state_d;

   logic                  bus_req_q, bus_req_d;
   logic                  bus_we_q, bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [31:0]           bus_wdata_q, bus_wdata_d;
   logic [3:0]            bus_be_q, bus_be_d;
   logic [63:0]           rd_data_q, rd_data_d;

   logic                  store_q, store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [31:0]           wdata_hi_q, wdata_hi_d;
   logic [31:0]           rdata_lo_q, rdata_lo_d;

   logic                  req_c;
   logic                  misalign_c;
   logic                  bad_c;
   logic                  ack_c;
   logic                  dword_c;
   logic                  stall_c;
   logic                  fault_c;
   logic                  unused_addr_hi;

   // Address bits above the bus width are deliberately dropped.
   assign unused_addr_hi = ^in_addr[63:ADDR_WIDTH];

   // Byte enables for the first beat; word and doubleword use all lanes.
   function automatic logic [3:0] beat_be(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << a;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Narrow store data is replicated so every lane carries it.
   function automatic logic [31:0] beat_wdata(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      case (size)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Lane select plus sign/zero extension; funct3[2] marks unsigned loads.
   function automatic logic [63:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
      logic [31:0] sh;
      logic [63:0] r;
      sh = lo >> {a, 3'b000};
      case (f3[1:0])
         2'b00:   r = f3[2] ? {56'h0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
         2'b01:   r = f3[2] ? {48'h0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         2'b10:   r = f3[2] ? {32'h0, sh}       : {{32{sh[31]}}, sh};
         default: r = {hi, lo};
      endcase
      return r;
   endfunction

   // Request decode and fault detection on the incoming request.
   always_comb begin
      case (in_funct3[1:0])
         2'b01:   misalign_c = in_addr[0];
         2'b10:   misalign_c = |in_addr[1:0];
         2'b11:   misalign_c = |in_addr[2:0];
         default: misalign_c = 1'b0;
      endcase
   end

   assign req_c   = in_wr_en | in_rd_en;
   assign bad_c   = (in_funct3 == 3'b111) | misalign_c | (in_wr_en & in_funct3[2]);
   assign ack_c   = in_bus_ack & bus_req_q;
   assign dword_c = (funct3_q[1:0] == 2'b11);

   // State register.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_c && !bad_c) state_d = ST_LO;
         ST_LO:   if (ack_c) state_d = dword_c ? ST_HI : ST_DONE;
         ST_HI:   if (ack_c) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next-value logic.
   always_comb begin
      stall_c     = 1'b0;
      fault_c     = 1'b0;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      rd_data_d   = rd_data_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_lo_d  = rdata_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               if (bad_c) begin
                  fault_c = 1'b1;
               end else begin
                  stall_c     = 1'b1;
                  store_d     = in_wr_en;
                  funct3_d    = in_funct3;
                  addr_lo_d   = in_addr[1:0];
                  wdata_hi_d  = in_wr_data[63:32];
                  bus_req_d   = 1'b1;
                  bus_we_d    = in_wr_en;
                  bus_addr_d  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
                  bus_be_d    = beat_be(in_funct3[1:0], in_addr[1:0]);
                  bus_wdata_d = beat_wdata(in_funct3[1:0], in_wr_data[31:0]);
               end
            end
         end
         ST_LO: begin
            stall_c = 1'b1;
            if (ack_c) begin
               rdata_lo_d = in_bus_rdata;
               if (dword_c) begin
                  // Request stays up; address and data switch to the upper beat.
                  bus_addr_d  = bus_addr_q + ADDR_WIDTH'(4);
                  bus_wdata_d = wdata_hi_q;
               end else begin
                  bus_req_d = 1'b0;
                  if (!store_q) rd_data_d = load_extract(funct3_q, addr_lo_q, in_bus_rdata, 32'h0);
               end
            end
         end
         ST_HI: begin
            stall_c = 1'b1;
            if (ack_c) begin
               bus_req_d = 1'b0;
               if (!store_q) rd_data_d = load_extract(funct3_q, addr_lo_q, rdata_lo_q, in_bus_rdata);
            end
         end
         default: ;
      endcase
   end

   // Datapath and bus registers.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         rd_data_q   <= '0;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         wdata_hi_q  <= '0;
         rdata_lo_q  <= '0;
      end else begin
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         rd_data_q   <= rd_data_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_lo_q  <= rdata_lo_d;
      end
   end

   // Combinational outputs are forced low while reset is held.
   assign out_stall     = stall_c & Rst_N;
   assign out_fault     = fault_c & Rst_N;
   assign out_rd_data   = rd_data_q;
   assign out_bus_req   = bus_req_q;
   assign out_bus_we    = bus_we_q;
   assign out_bus_addr  = bus_addr_q;
   assign out_bus_wdata = bus_wdata_q;
   assign out_bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a byte-addressed memory model and a transaction-level
// expectation of bus beats, stall cycles and load results.
module tb_mem_access_unit;

   logic        Clk;
   logic        Rst_N;
   logic [63:0] in_addr;
   logic [63:0] in_wr_data;
   logic        in_wr_en;
   logic        in_rd_en;
   logic [2:0]  in_funct3;
   logic [63:0] out_rd_data;
   logic        out_stall;
   logic        out_fault;
   logic        out_bus_req;
   logic        out_bus_we;
   logic [31:0] out_bus_addr;
   logic [31:0] out_bus_wdata;
   logic [3:0]  out_bus_be;
   logic        in_bus_ack;
   logic [31:0] in_bus_rdata;

   mem_access_unit #(.ADDR_WIDTH(32)) dut (
      .Clk          (Clk),
      .Rst_N        (Rst_N),
      .in_addr      (in_addr),
      .in_wr_data   (in_wr_data),
      .in_wr_en     (in_wr_en),
      .in_rd_en     (in_rd_en),
      .in_funct3    (in_funct3),
      .out_rd_data  (out_rd_data),
      .out_stall    (out_stall),
      .out_fault    (out_fault),
      .out_bus_req  (out_bus_req),
      .out_bus_we   (out_bus_we),
      .out_bus_addr (out_bus_addr),
      .out_bus_wdata(out_bus_wdata),
      .out_bus_be   (out_bus_be),
      .in_bus_ack   (in_bus_ack),
      .in_bus_rdata (in_bus_rdata)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] prev_rd;
   logic [7:0]  mem [int unsigned];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
   endfunction

   task automatic put_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
   endtask

   task automatic drop_inputs();
      in_wr_en   = 1'b0;
      in_rd_en   = 1'b0;
      in_funct3  = 3'b000;
      in_addr    = '0;
      in_wr_data = '0;
   endtask

   // One pipeline access from the IDLE cycle to the return to IDLE.
   // Called at a negedge; every beat is acked after 'waits' empty cycles.
   task automatic do_access(input bit wr, input bit rd, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] data,
                            input int waits);
      int          sz;
      int          nbeats;
      int          stalls;
      bit          exp_fault;
      logic [31:0] a32;
      logic [31:0] ba;
      logic [63:0] exp_rd;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      sz        = 1 << f3[1:0];
      a32       = addr[31:0];
      ba        = {a32[31:2], 2'b00};
      exp_fault = (f3 == 3'b111) || ((a32 & 32'(sz - 1)) != 0) || (wr && f3[2]);
      nbeats    = (sz == 8) ? 2 : 1;

      in_wr_en   = wr;
      in_rd_en   = rd;
      in_funct3  = f3;
      in_addr    = addr;
      in_wr_data = data;
      #1;
      if (!(wr || rd)) begin
         in_bus_ack = 1'b1;   // stray ack while idle must be ignored
         check_eq("idle_stall", 64'(out_stall), 64'd0);
         check_eq("idle_fault", 64'(out_fault), 64'd0);
         @(posedge Clk);
         @(negedge Clk);
         in_bus_ack = 1'b0;
         check_eq("idle_req", 64'(out_bus_req), 64'd0);
         check_eq("idle_rd", out_rd_data, prev_rd);
         return;
      end
      if (exp_fault) begin
         check_eq("flt_fault", 64'(out_fault), 64'd1);
         check_eq("flt_stall", 64'(out_stall), 64'd0);
         @(posedge Clk);
         @(negedge Clk);
         check_eq("flt_req", 64'(out_bus_req), 64'd0);
         check_eq("flt_rd", out_rd_data, prev_rd);
         drop_inputs();
         return;
      end
      check_eq("acc_fault", 64'(out_fault), 64'd0);
      check_eq("acc_stall0", 64'(out_stall), 64'd1);

      // Expected load value from the byte-addressed memory image.
      exp_rd = prev_rd;
      if (!wr) begin
         exp_rd = '0;
         for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = rd_byte(a32 + 32'(i));
         if (!f3[2] && sz < 8 && exp_rd[8*sz-1])
            for (int i = 8*sz; i < 64; i++) exp_rd[i] = 1'b1;
      end
      exp_be = 4'b0000;
      if (sz >= 4) exp_be = 4'b1111;
      else for (int i = 0; i < sz; i++) exp_be[int'(a32[1:0]) + i] = 1'b1;

      stalls = 1;
      @(posedge Clk);
      for (int b = 0; b < nbeats; b++) begin
         if (b == 1) exp_wd = data[63:32];
         else if (sz == 1) exp_wd = {4{data[7:0]}};
         else if (sz == 2) exp_wd = {2{data[15:0]}};
         else exp_wd = data[31:0];
         for (int w = 0; w <= waits; w++) begin
            @(negedge Clk);
            check_eq("beat_req", 64'(out_bus_req), 64'd1);
            check_eq("beat_addr", 64'(out_bus_addr), 64'(ba + 32'(4*b)));
            if (w == 0) begin
               check_eq("beat_we", 64'(out_bus_we), 64'(wr));
               check_eq("beat_be", 64'(out_bus_be), 64'(exp_be));
               if (wr) check_eq("beat_wdata", 64'(out_bus_wdata), 64'(exp_wd));
            end
            if (out_stall) stalls++;
            in_bus_ack   = (w == waits);
            in_bus_rdata = (w == waits && !wr) ? bus_word(ba + 32'(4*b)) : $urandom;
            @(posedge Clk);
         end
      end
      @(negedge Clk);
      in_bus_ack = 1'b0;   // DONE cycle: ack ignored either way
      check_eq("done_stall", 64'(out_stall), 64'd0);
      check_eq("done_req", 64'(out_bus_req), 64'd0);
      check_eq("done_rd", out_rd_data, exp_rd);
      check_eq("stall_cycles", 64'(stalls), 64'(1 + nbeats * (waits + 1)));
      if (wr) for (int i = 0; i < sz; i++) mem[a32 + 32'(i)] = data[8*i +: 8];
      else prev_rd = exp_rd;
      drop_inputs();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   initial begin
      Rst_N        = 1'b0;
      in_bus_ack   = 1'b0;
      in_bus_rdata = '0;
      drop_inputs();
      prev_rd      = '0;

      // Reset: outputs at reset values even with a request presented.
      in_rd_en  = 1'b1;
      in_funct3 = 3'b111;
      in_addr   = 64'h1001;
      #12;
      check_eq("rst_stall", 64'(out_stall), 64'd0);
      check_eq("rst_fault", 64'(out_fault), 64'd0);
      check_eq("rst_req", 64'(out_bus_req), 64'd0);
      check_eq("rst_we", 64'(out_bus_we), 64'd0);
      check_eq("rst_addr", 64'(out_bus_addr), 64'd0);
      check_eq("rst_wdata", 64'(out_bus_wdata), 64'd0);
      check_eq("rst_be", 64'(out_bus_be), 64'd0);
      check_eq("rst_rd", out_rd_data, 64'd0);
      drop_inputs();
      @(negedge Clk);
      Rst_N = 1'b1;
      @(negedge Clk);

      // Directed cases.
      put_word(32'h1004, 32'h8000_0001);
      do_access(1'b0, 1'b1, 3'b010, 64'h1004, 64'h0, 0);
      check_eq("tp_lw", out_rd_data, 64'hFFFF_FFFF_8000_0001);
      put_word(32'h2000, 32'hAB00_0000);
      do_access(1'b0, 1'b1, 3'b100, 64'h2003, 64'h0, 3);
      check_eq("tp_lbu", out_rd_data, 64'h0000_0000_0000_00AB);
      do_access(1'b1, 1'b0, 3'b011, 64'h3000, 64'h1122_3344_5566_7788, 0);
      check_eq("tp_sd_rd", out_rd_data, 64'h0000_0000_0000_00AB);
      do_access(1'b0, 1'b1, 3'b011, 64'h3000, 64'h0, 1);
      check_eq("tp_ld", out_rd_data, 64'h1122_3344_5566_7788);
      do_access(1'b1, 1'b0, 3'b001, 64'h4001, 64'hBEEF, 0);
      do_access(1'b0, 1'b1, 3'b011, 64'h4004, 64'h0, 0);
      do_access(1'b1, 1'b0, 3'b000, 64'h5002, 64'h5A, 2);
      do_access(1'b0, 1'b1, 3'b000, 64'h5002, 64'h0, 0);
      check_eq("tp_sb_lb", out_rd_data, 64'h0000_0000_0000_005A);
      do_access(1'b1, 1'b1, 3'b001, 64'hFFFF_0000_0000_5004, 64'h8001, 0);
      do_access(1'b0, 1'b1, 3'b001, 64'h5004, 64'h0, 0);
      check_eq("tp_lh_sx", out_rd_data, 64'hFFFF_FFFF_FFFF_8001);

      // Reset asserted during the HI beat of a doubleword load.
      put_word(32'h6000, 32'hCAFE_F00D);
      put_word(32'h6004, 32'h0BAD_BEEF);
      in_rd_en  = 1'b1;
      in_funct3 = 3'b011;
      in_addr   = 64'h6000;
      @(posedge Clk);
      @(negedge Clk);
      in_bus_ack   = 1'b1;
      in_bus_rdata = bus_word(32'h6000);
      @(posedge Clk);
      @(negedge Clk);
      in_bus_ack = 1'b0;
      check_eq("hi_req", 64'(out_bus_req), 64'd1);
      check_eq("hi_addr", 64'(out_bus_addr), 64'h6004);
      Rst_N = 1'b0;
      #1;
      check_eq("midrst_req", 64'(out_bus_req), 64'd0);
      check_eq("midrst_stall", 64'(out_stall), 64'd0);
      check_eq("midrst_rd", out_rd_data, 64'd0);
      check_eq("midrst_be", 64'(out_bus_be), 64'd0);
      drop_inputs();
      prev_rd = '0;
      @(negedge Clk);
      Rst_N = 1'b1;
      @(negedge Clk);
      do_access(1'b0, 1'b1, 3'b010, 64'h6000, 64'h0, 0);
      check_eq("post_rst_lw", out_rd_data, 64'hFFFF_FFFF_CAFE_F00D);

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         int          kind;
         bit          wr;
         bit          rd;
         logic [2:0]  f3;
         logic [31:0] off;
         logic [63:0] addr;
         kind = $urandom_range(0, 9);
         wr   = (kind < 4);
         rd   = (kind >= 4 && kind < 9) || (kind == 0);
         f3   = 3'($urandom_range(0, 7));
         if (wr && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
         off = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 8) off = off & ~32'((1 << f3[1:0]) - 1);
         addr = {32'($urandom), 32'h0000_0100 + off};
         do_access(wr, rd, f3, addr, {32'($urandom), 32'($urandom)}, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
